mag_compare_serial_acc: RTL and testbench
=========================================

MAG_COMPARE_SERIAL_ACC -- requirements
Module: mag_compare_serial_acc

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning the number of 2-bit comparator slices per word, legal range 1..16.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port valid_i  input  1  a digit result is present this cycle.
REQ-005 SHALL have port sop_i  input  1  the digit is the MSB slice of a new word; qualified by valid_i.
REQ-006 SHALL have port greater_i  input  1  the slice comparator reports in1 > in2 for this slice.
REQ-007 SHALL have port equal_i  input  1  the slice comparator reports in1 == in2 for this slice.
REQ-008 SHALL have port lesser_i  input  1  the slice comparator reports in1 < in2 for this slice.
REQ-009 SHALL have port busy_o  output  1  a word is in progress (state not IDLE).
REQ-010 SHALL have port done_o  output  1  one-cycle pulse; the word result is valid this cycle.
REQ-011 SHALL have port greater_o, equal_o, lesser_o  output  1 each  registered word result, held until the next done_o.
REQ-012 SHALL have port err_o  output  1  one-cycle pulse with done_o when the word contained an illegal flag set.

Function
REQ-013 SHALL accept one digit per cycle when valid_i=1; digits arrive MSB slice first; valid_i=0 cycles are gaps and change no state.
REQ-014 SHALL implement FSM states IDLE, EQ (all digits so far equal), GT, and LT.
REQ-015 IDLE: valid_i&sop_i SHALL go to GT/LT/EQ per the digit flags; valid_i without sop_i SHALL be ignored.
REQ-016 EQ: greater_i SHALL go to GT, lesser_i to LT, and equal_i to stay in EQ (G = Gmsb + Emsb.Glsb; L likewise).
REQ-017 GT/LT: later digits SHALL be counted but SHALL NOT change the decision.
REQ-018 SHALL keep a digit counter of width clog2(NUM_DIGITS+1): set to 1 on an accepted sop digit, incremented on each other accepted digit.
REQ-019 When the accepted digit is the NUM_DIGITS-th, the block SHALL, at that edge, load greater_o/equal_o/lesser_o from the final decision (exactly one high), assert done_o for the next cycle only, and return to IDLE.
REQ-020 Latency SHALL be 1 cycle from the final-digit clock edge to done_o.
REQ-021 NUM_DIGITS=1: each valid&sop digit SHALL complete a word by itself.
REQ-022 A sop_i with valid_i while busy SHALL abort the current word without done_o and restart with this digit; sop_i takes priority over completion of the old word.
REQ-023 A new sop digit in the same cycle that done_o is high SHALL be accepted with no bubble.
REQ-024 Results SHALL hold unchanged between done_o pulses, including across aborted words.

Reset
REQ-025 rst_n_i low SHALL immediately force state IDLE, counter 0, busy_o=0, done_o=0, err_o=0, greater_o=0, equal_o=0, lesser_o=0.
REQ-026 A reset asserted mid-word SHALL discard the word; no done_o SHALL follow deassertion.
REQ-027 Deassertion SHALL be synchronised inside the block so that the first accepted digit is at the second rising edge after release.

Configuration
REQ-028 With macro MAG_CMP_FLAG_CHECK_EN defined, any accepted digit whose flags are not exactly one-hot SHALL mark the word; at completion err_o SHALL pulse with done_o and all three result outputs SHALL be 0.
REQ-029 Without MAG_CMP_FLAG_CHECK_EN, err_o SHALL be tied 0 and flags SHALL be decoded by priority greater_i > lesser_i > equal_i (all-zero decodes as equal).

Verification (NUM_DIGITS=4)
REQ-030 Digits E,E,G,L (sop on the first), no gaps -> done_o on the cycle after the 4th digit, greater_o=1, equal_o=0, lesser_o=0.
REQ-031 Digits E,E,E,E with a valid_i=0 gap after the 2nd digit -> done_o 1 cycle after the 4th digit, equal_o=1; busy_o high throughout the gap.
REQ-032 Digits L,G then sop with G,E,E,E -> no done_o for the aborted word; a single done_o with greater_o=1.
REQ-033 Reset pulse after 2 digits, then a full word L,E,E,E -> outputs all 0 during reset; a single done_o with lesser_o=1.
REQ-034 With the macro defined, digits E,(G&L),E,E -> done_o and err_o pulse together with results 000; without the macro, the same stimulus gives greater_o=1 and err_o=0.
REQ-035 Back-to-back words G,E,E,E then sop L,E,E,E with no gap -> two done_o pulses 4 cycles apart, GT then LT.

Source files
------------

// File: rtl/mag_compare_serial_acc.sv
// Serial magnitude-compare accumulator: folds MSB-first 2-bit slice flags into a word result.
// Optional one-hot flag checking is enabled by defining MAG_CMP_FLAG_CHECK_EN.
module mag_compare_serial_acc #(
  parameter int NUM_DIGITS = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic valid_i,
  input  logic sop_i,
  input  logic greater_i,
  input  logic equal_i,
  input  logic lesser_i,
  output logic busy_o,
  output logic done_o,
  output logic greater_o,
  output logic equal_o,
  output logic lesser_o,
  output logic err_o
);

  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(NUM_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EQ,
    S_GT,
    S_LT
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  state_t          w_decision;
  state_t          w_digState;
  logic            r_runEn;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cntNext;
  logic            w_accept;
  logic            w_start;
  logic            w_inWord;
  logic            w_last;
  logic            w_wordBad;
  logic            w_resGt;
  logic            w_resEq;
  logic            w_resLt;
  logic            r_done;
  logic            r_gt;
  logic            r_eq;
  logic            r_lt;

  // Single-flop release gate: digits are taken from the second edge after reset release.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_runEn <= 1'b0;
    end else begin
      r_runEn <= 1'b1;
    end
  end

  assign w_accept  = valid_i & r_runEn;
  assign w_start   = w_accept & sop_i;
  assign w_inWord  = w_start | (w_accept & (r_state != S_IDLE));
  assign w_cntNext = w_start ? CW'(1) : r_cnt + CW'(1);
  assign w_last    = w_inWord & (w_cntNext == LP_LAST);

  always_comb begin
    w_digState = S_EQ;
    if (greater_i) begin
      w_digState = S_GT;
    end else if (lesser_i) begin
      w_digState = S_LT;
    end
  end

  // Decision after this digit, before any return to IDLE on completion.
  always_comb begin
    w_decision = r_state;
    if (w_start) begin
      w_decision = w_digState;
    end else if (w_accept && (r_state == S_EQ)) begin
      w_decision = w_digState;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = w_decision;
    if (w_last) begin
      w_nextState = S_IDLE;
    end
  end

  always_comb begin
    busy_o  = (r_state != S_IDLE);
    w_resGt = ~w_wordBad & (w_decision == S_GT);
    w_resEq = ~w_wordBad & (w_decision == S_EQ);
    w_resLt = ~w_wordBad & (w_decision == S_LT);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else if (w_inWord) begin
      r_cnt <= w_cntNext;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_done <= 1'b0;
      r_gt   <= 1'b0;
      r_eq   <= 1'b0;
      r_lt   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_last) begin
        r_gt <= w_resGt;
        r_eq <= w_resEq;
        r_lt <= w_resLt;
      end
    end
  end

`ifdef MAG_CMP_FLAG_CHECK_EN
  logic r_errMark;
  logic r_err;
  logic w_digBad;

  assign w_digBad  = ~(( greater_i & ~equal_i & ~lesser_i) |
                       (~greater_i &  equal_i & ~lesser_i) |
                       (~greater_i & ~equal_i &  lesser_i));
  assign w_wordBad = w_digBad | (~w_start & r_errMark);

  // A bad digit taints the whole word; the mark is cleared by a new sop or completion.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_errMark <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_last & w_wordBad;
      if (w_last) begin
        r_errMark <= 1'b0;
      end else if (w_inWord) begin
        r_errMark <= w_wordBad;
      end
    end
  end

  assign err_o = r_err;
`else
  assign w_wordBad = 1'b0;
  assign err_o     = 1'b0;
`endif

  assign done_o    = r_done;
  assign greater_o = r_gt;
  assign equal_o   = r_eq;
  assign lesser_o  = r_lt;

endmodule

// File: tb/tb_mag_compare_serial_acc.sv
// Self-checking bench for mag_compare_serial_acc (NUM_DIGITS=4) against a word-level reference model.
module tb_mag_compare_serial_acc;

  localparam int N = 4;
  localparam logic [2:0] D_G  = 3'b100;
  localparam logic [2:0] D_E  = 3'b010;
  localparam logic [2:0] D_L  = 3'b001;
  localparam logic [2:0] D_GL = 3'b101;
  localparam logic [2:0] D_0  = 3'b000;

  logic clk_i = 1'b0;
  logic rst_n_i, valid_i, sop_i, greater_i, equal_i, lesser_i;
  logic busy_o, done_o, greater_o, equal_o, lesser_o, err_o;

  int testsRun = 0;
  int testsFailed = 0;

  bit         inWord;
  logic [2:0] digits[$];
  logic       expDone, expBusy, expG, expE, expL, expErr;

  mag_compare_serial_acc #(.NUM_DIGITS(N)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .sop_i(sop_i),
    .greater_i(greater_i), .equal_i(equal_i), .lesser_i(lesser_i),
    .busy_o(busy_o), .done_o(done_o), .greater_o(greater_o), .equal_o(equal_o),
    .lesser_o(lesser_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Word result = first slice that is not equal, scanning from the MSB; returns {g,e,l,err}.
  function automatic logic [3:0] wordResult();
`ifdef MAG_CMP_FLAG_CHECK_EN
    foreach (digits[i])
      if (!(digits[i] == D_G || digits[i] == D_E || digits[i] == D_L)) return 4'b0001;
`endif
    foreach (digits[i]) begin
      if (digits[i][2]) return 4'b1000;
      if (digits[i][0]) return 4'b0010;
    end
    return 4'b0100;
  endfunction

  task automatic modelReset();
    inWord = 1'b0;
    digits.delete();
    {expDone, expBusy, expG, expE, expL, expErr} = 6'b0;
  endtask

  // Drives one cycle of inputs, advances the model over the edge, returns #1 after it.
  task automatic stepDigit(input logic v, input logic s, input logic [2:0] f);
    logic [3:0] r;
    valid_i = v;
    sop_i   = s;
    {greater_i, equal_i, lesser_i} = f;
    @(posedge clk_i);
    expDone = 1'b0;
    expErr  = 1'b0;
    if (v) begin
      if (s) begin
        digits.delete();
        inWord = 1'b1;
      end
      if (inWord) begin
        digits.push_back(f);
        if (digits.size() == N) begin
          r = wordResult();
          {expG, expE, expL, expErr} = r;
          expDone = 1'b1;
          inWord  = 1'b0;
        end
      end
    end
    expBusy = inWord;
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    valid_i = 1'b0; sop_i = 1'b0; {greater_i, equal_i, lesser_i} = D_0;
    modelReset();
    #1;
    testsRun++;
    if ({busy_o, done_o, greater_o, equal_o, lesser_o, err_o} !== 6'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got %b expected 000000",
               {busy_o, done_o, greater_o, equal_o, lesser_o, err_o});
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    valid_i = 1'b1; sop_i = 1'b1; {greater_i, equal_i, lesser_i} = D_G;
    @(posedge clk_i);
    #1;
    testsRun++;
    if (busy_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_first_edge_ignored: got busy %b expected 0", busy_o);
    end
    stepDigit(1'b1, 1'b1, D_G);
    testsRun++;
    if (busy_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_second_edge_accepted: got busy %b expected 1", busy_o);
    end
    for (int i = 0; i < 3; i++) stepDigit(1'b1, 1'b0, D_E);
    testsRun++;
    if ({done_o, greater_o, equal_o, lesser_o} !== 4'b1100) begin
      testsFailed++;
      $display("[TB] FAIL reset_first_word: got %b expected 1100",
               {done_o, greater_o, equal_o, lesser_o});
    end
    stepDigit(1'b0, 1'b0, D_0);
  endtask

  task automatic test_greater_word();
    logic [2:0] seq[4] = '{D_E, D_E, D_G, D_L};
    for (int i = 0; i < 4; i++) begin
      stepDigit(1'b1, i == 0, seq[i]);
      testsRun++;
      if ({done_o, busy_o} !== {i == 3, i != 3}) begin
        testsFailed++;
        $display("[TB] FAIL eegl_step%0d: got done/busy %b%b expected %b%b",
                 i, done_o, busy_o, i == 3, i != 3);
      end
    end
    testsRun++;
    if ({greater_o, equal_o, lesser_o, err_o} !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL eegl_result: got %b expected 1000", {greater_o, equal_o, lesser_o, err_o});
    end
    stepDigit(1'b0, 1'b0, D_0);
    testsRun++;
    if ({done_o, greater_o} !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL eegl_pulse_hold: got done/gt %b expected 01", {done_o, greater_o});
    end
  endtask

  task automatic test_gap();
    logic       vSeq[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] expDb[5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 5; i++) begin
      stepDigit(vSeq[i], i == 0, vSeq[i] ? D_E : D_0);
      testsRun++;
      if ({done_o, busy_o} !== expDb[i]) begin
        testsFailed++;
        $display("[TB] FAIL gap_step%0d: got done/busy %b%b expected %b", i, done_o, busy_o, expDb[i]);
      end
    end
    testsRun++;
    if ({greater_o, equal_o, lesser_o} !== 3'b010) begin
      testsFailed++;
      $display("[TB] FAIL gap_result: got %b expected 010", {greater_o, equal_o, lesser_o});
    end
  endtask

  task automatic test_abort();
    logic [2:0] seq[6] = '{D_L, D_G, D_G, D_E, D_E, D_E};
    logic       sSeq[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      stepDigit(1'b1, sSeq[i], seq[i]);
      testsRun++;
      if (done_o !== (i == 5)) begin
        testsFailed++;
        $display("[TB] FAIL abort_done_step%0d: got %b expected %b", i, done_o, i == 5);
      end
      if (i < 5) begin
        testsRun++;
        if ({greater_o, equal_o, lesser_o} !== 3'b010) begin
          testsFailed++;
          $display("[TB] FAIL abort_hold_step%0d: got %b expected 010", i, {greater_o, equal_o, lesser_o});
        end
      end
    end
    testsRun++;
    if ({greater_o, equal_o, lesser_o} !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL abort_result: got %b expected 100", {greater_o, equal_o, lesser_o});
    end
  endtask

  task automatic test_reset_midword();
    logic [2:0] seq[4] = '{D_L, D_E, D_E, D_E};
    stepDigit(1'b1, 1'b1, D_G);
    stepDigit(1'b1, 1'b0, D_E);
    valid_i = 1'b0; sop_i = 1'b0;
    #2 rst_n_i = 1'b0;
    modelReset();
    #1;
    testsRun++;
    if ({busy_o, done_o, greater_o, equal_o, lesser_o, err_o} !== 6'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_outputs: got %b expected 000000",
               {busy_o, done_o, greater_o, equal_o, lesser_o, err_o});
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 4; i++) begin
      stepDigit(1'b1, i == 0, seq[i]);
      testsRun++;
      if (done_o !== (i == 3)) begin
        testsFailed++;
        $display("[TB] FAIL midreset_done_step%0d: got %b expected %b", i, done_o, i == 3);
      end
    end
    testsRun++;
    if ({greater_o, equal_o, lesser_o} !== 3'b001) begin
      testsFailed++;
      $display("[TB] FAIL midreset_result: got %b expected 001", {greater_o, equal_o, lesser_o});
    end
  endtask

  task automatic test_flag_check();
    logic [2:0] seq[4] = '{D_E, D_GL, D_E, D_E};
    logic [4:0] want;
`ifdef MAG_CMP_FLAG_CHECK_EN
    want = 5'b11000;
`else
    want = 5'b10100;
`endif
    for (int i = 0; i < 4; i++) stepDigit(1'b1, i == 0, seq[i]);
    testsRun++;
    if ({done_o, err_o, greater_o, equal_o, lesser_o} !== want) begin
      testsFailed++;
      $display("[TB] FAIL flag_result: got %b expected %b", {done_o, err_o, greater_o, equal_o, lesser_o}, want);
    end
    stepDigit(1'b0, 1'b0, D_0);
    testsRun++;
    if ({done_o, err_o} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL flag_pulse_end: got done/err %b expected 00", {done_o, err_o});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq[9] = '{D_G, D_E, D_E, D_E, D_L, D_E, D_E, D_E, D_0};
    int         doneAt[$];
    logic [2:0] res[$];
    for (int i = 0; i < 9; i++) begin
      stepDigit(i < 8, (i == 0) || (i == 4), seq[i]);
      testsRun++;
      if ({done_o, busy_o, greater_o, equal_o, lesser_o, err_o} !== {expDone, expBusy, expG, expE, expL, expErr}) begin
        testsFailed++;
        $display("[TB] FAIL b2b_model_step%0d: got %b expected %b", i,
                 {done_o, busy_o, greater_o, equal_o, lesser_o, err_o},
                 {expDone, expBusy, expG, expE, expL, expErr});
      end
      if (done_o === 1'b1) begin
        doneAt.push_back(i);
        res.push_back({greater_o, equal_o, lesser_o});
      end
    end
    testsRun++;
    if (doneAt.size() != 2) begin
      testsFailed++;
      $display("[TB] FAIL b2b_done_count: got %0d expected 2", doneAt.size());
    end else begin
      testsRun++;
      if ((doneAt[1] - doneAt[0]) != 4 || res[0] !== 3'b100 || res[1] !== 3'b001) begin
        testsFailed++;
        $display("[TB] FAIL b2b_spacing_results: got gap %0d res %b/%b expected gap 4 res 100/001",
                 doneAt[1] - doneAt[0], res[0], res[1]);
      end
    end
  endtask

  task automatic test_random();
    logic       v, s;
    logic [2:0] f;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 4) == 0) begin
        f = 3'($urandom_range(0, 7));
      end else begin
        case ($urandom_range(0, 2))
          0:       f = D_G;
          1:       f = D_E;
          default: f = D_L;
        endcase
      end
      stepDigit(v, s, f);
      testsRun++;
      if ({done_o, busy_o, greater_o, equal_o, lesser_o, err_o} !== {expDone, expBusy, expG, expE, expL, expErr}) begin
        testsFailed++;
        $display("[TB] FAIL random_cycle%0d: got %b expected %b", i,
                 {done_o, busy_o, greater_o, equal_o, lesser_o, err_o},
                 {expDone, expBusy, expG, expE, expL, expErr});
      end
    end
  endtask

  initial begin
    test_reset();
    test_greater_word();
    test_gap();
    test_abort();
    test_reset_midword();
    test_flag_check();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
